matmul_tile_scheduler: RTL and testbench

//  Top-level sequencer for one DiP matrix-multiply job C[MxK] = A[MxN] * B[NxK].
//  On start: latches the job, pulses err_cal into error_check, then samples err_found.
//  If the job is legal, walks all 4x4 tiles and issues one tile command per step to the systolic array.

---
 rtl/matmul_tile_scheduler.sv | 165 ++++++++++++++++
 tb/tb_matmul_tile_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler: sequences one tiled C=A*B job, validating it first and then issuing one command per 4x4 tile step
module matmul_tile_scheduler #(
    parameter int TILE   = 4,
    parameter int DIM_W  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DIM_W-1:0]  m_i,
    input  logic [DIM_W-1:0]  n_i,
    input  logic [DIM_W-1:0]  k_i,
    input  logic [ADDR_W-1:0] base_addr_in1_i,
    input  logic [ADDR_W-1:0] base_addr_in2_i,
    input  logic [ADDR_W-1:0] base_addr_out_i,
    output logic              err_cal_o,
    input  logic              err_found_i,
    output logic              tile_valid_o,
    input  logic              tile_ready_i,
    output logic [ADDR_W-1:0] tile_addr_a_o,
    output logic [ADDR_W-1:0] tile_addr_b_o,
    output logic [ADDR_W-1:0] tile_addr_c_o,
    output logic [DIM_W-1:0]  stride_a_o,
    output logic [DIM_W-1:0]  stride_bc_o,
    output logic              tile_acc_clr_o,
    output logic              tile_last_o,
    input  logic              tile_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);
    typedef enum logic [2:0] {IDLE, CHECK, EVAL, ISSUE, WAIT, ADV, DONE} state_t;
    state_t            state_q;
    logic [DIM_W-1:0]  mt_q, nt_q, kt_q, mi_q, ni_q, ki_q, mi_d, ni_d, ki_d;
    logic [DIM_W-1:0]  stride_a_q, stride_bc_q;
    logic [ADDR_W-1:0] in2_q, step_a_q, step_bc_q, a_row_q, c_row_q, col_q;
    logic [ADDR_W-1:0] a_row_d, c_row_d, col_d;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q, addr_c_q, addr_a_d, addr_b_d, addr_c_d;
    logic              err_cal_q, tile_valid_q, acc_clr_q, last_q, busy_q, done_q, error_q;
    logic              ni_wrap, ki_wrap, mi_wrap, row_wrap;
    // Running offsets: A and B step by constant amounts along N, so only adders are needed.
    always_comb begin
        ni_wrap  = ni_q == nt_q - DIM_W'(1);
        ki_wrap  = ki_q == kt_q - DIM_W'(1);
        mi_wrap  = mi_q == mt_q - DIM_W'(1);
        row_wrap = ni_wrap && ki_wrap;
        ni_d     = ni_wrap ? '0 : ni_q + DIM_W'(1);
        ki_d     = ni_wrap ? (ki_wrap ? '0 : ki_q + DIM_W'(1)) : ki_q;
        mi_d     = row_wrap ? mi_q + DIM_W'(1) : mi_q;
        a_row_d  = row_wrap ? a_row_q + step_a_q : a_row_q;
        c_row_d  = row_wrap ? c_row_q + step_bc_q : c_row_q;
        col_d    = ni_wrap ? (ki_wrap ? '0 : col_q + ADDR_W'(TILE)) : col_q;
        addr_a_d = ni_wrap ? a_row_d : addr_a_q + ADDR_W'(TILE);
        addr_b_d = ni_wrap ? in2_q + col_d : addr_b_q + step_bc_q;
        addr_c_d = c_row_d + col_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mt_q         <= '0;
            nt_q         <= '0;
            kt_q         <= '0;
            mi_q         <= '0;
            ni_q         <= '0;
            ki_q         <= '0;
            stride_a_q   <= '0;
            stride_bc_q  <= '0;
            in2_q        <= '0;
            step_a_q     <= '0;
            step_bc_q    <= '0;
            a_row_q      <= '0;
            c_row_q      <= '0;
            col_q        <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            addr_c_q     <= '0;
            err_cal_q    <= 1'b0;
            tile_valid_q <= 1'b0;
            acc_clr_q    <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            err_cal_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    mt_q        <= DIM_W'(m_i / TILE);
                    nt_q        <= DIM_W'(n_i / TILE);
                    kt_q        <= DIM_W'(k_i / TILE);
                    mi_q        <= '0;
                    ni_q        <= '0;
                    ki_q        <= '0;
                    stride_a_q  <= n_i;
                    stride_bc_q <= k_i;
                    in2_q       <= base_addr_in2_i;
                    step_a_q    <= ADDR_W'(TILE * n_i);
                    step_bc_q   <= ADDR_W'(TILE * k_i);
                    a_row_q     <= base_addr_in1_i;
                    c_row_q     <= base_addr_out_i;
                    col_q       <= '0;
                    addr_a_q    <= base_addr_in1_i;
                    addr_b_q    <= base_addr_in2_i;
                    addr_c_q    <= base_addr_out_i;
                    error_q     <= 1'b0;
                    busy_q      <= 1'b1;
                    err_cal_q   <= 1'b1;
                    state_q     <= CHECK;
                end
                CHECK: state_q <= EVAL;
                EVAL: if (err_found_i) begin
                    error_q <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end else begin
                    tile_valid_q <= 1'b1;
                    acc_clr_q    <= 1'b1;
                    last_q       <= nt_q == DIM_W'(1);
                    state_q      <= ISSUE;
                end
                ISSUE: if (tile_ready_i) begin
                    tile_valid_q <= 1'b0;
                    state_q      <= WAIT;
                end
                WAIT: if (tile_done_i) state_q <= ADV;
                ADV: if (row_wrap && mi_wrap) begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end else begin
                    mi_q         <= mi_d;
                    ni_q         <= ni_d;
                    ki_q         <= ki_d;
                    a_row_q      <= a_row_d;
                    c_row_q      <= c_row_d;
                    col_q        <= col_d;
                    addr_a_q     <= addr_a_d;
                    addr_b_q     <= addr_b_d;
                    addr_c_q     <= addr_c_d;
                    acc_clr_q    <= ni_d == '0;
                    last_q       <= ni_d == nt_q - DIM_W'(1);
                    tile_valid_q <= 1'b1;
                    state_q      <= ISSUE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign err_cal_o      = err_cal_q;
    assign tile_valid_o   = tile_valid_q;
    assign tile_addr_a_o  = addr_a_q;
    assign tile_addr_b_o  = addr_b_q;
    assign tile_addr_c_o  = addr_c_q;
    assign stride_a_o     = stride_a_q;
    assign stride_bc_o    = stride_bc_q;
    assign tile_acc_clr_o = acc_clr_q;
    assign tile_last_o    = last_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// tb_matmul_tile_scheduler: directed checks of job acceptance, tile walk order, stalls, rejection and reset abort
module tb_matmul_tile_scheduler;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [3:0] m = '0, n = '0, k = '0;
    logic [9:0] b1 = '0, b2 = '0, bo = '0;
    logic       err_found = 1'b0, tile_ready = 1'b0, tile_done = 1'b0;
    logic       err_cal, tile_valid, acc_clr, last, busy, done, error;
    logic [9:0] addr_a, addr_b, addr_c;
    logic [3:0] stride_a, stride_bc;
    int         n_cmp = 0, n_err = 0, hs = 0, dones = 0, dones_before;

    matmul_tile_scheduler dut (
        .clk(clk), .rst(rst), .start_i(start), .m_i(m), .n_i(n), .k_i(k),
        .base_addr_in1_i(b1), .base_addr_in2_i(b2), .base_addr_out_i(bo),
        .err_cal_o(err_cal), .err_found_i(err_found),
        .tile_valid_o(tile_valid), .tile_ready_i(tile_ready),
        .tile_addr_a_o(addr_a), .tile_addr_b_o(addr_b), .tile_addr_c_o(addr_c),
        .stride_a_o(stride_a), .stride_bc_o(stride_bc),
        .tile_acc_clr_o(acc_clr), .tile_last_o(last), .tile_done_i(tile_done),
        .busy_o(busy), .done_o(done), .error_o(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tile_valid && tile_ready) hs <= hs + 1;
        if (done) dones <= dones + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns in the EVAL cycle (cycle 2 after the accepting edge).
    task automatic launch(input logic [3:0] mm, nn, kk, input logic [9:0] a1, a2, ao, input logic ef);
        m = mm; n = nn; k = kk; b1 = a1; b2 = a2; bo = ao;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("err_cal_c1", err_cal, 1);
        chk("busy_c1", busy, 1);
        chk("error_clr_c1", error, 0);
        err_found = ef;
        tick;
        chk("err_cal_c2", err_cal, 0);
        chk("valid_c2", tile_valid, 0);
    endtask

    // Returns in the ADV cycle after the tile_done pulse.
    task automatic do_tile(input logic [9:0] a, b, c, input logic clr, lst, input int stall, input logic poke);
        for (int i = 0; i < 20 && !tile_valid; i++) tick;
        chk("tile_valid", tile_valid, 1);
        chk("addr_a", addr_a, a);
        chk("addr_b", addr_b, b);
        chk("addr_c", addr_c, c);
        chk("acc_clr", acc_clr, clr);
        chk("last", last, lst);
        for (int i = 0; i < stall; i++) begin
            tick;
            chk("stall_valid", tile_valid, 1);
            chk("stall_addr_a", addr_a, a);
            chk("stall_addr_b", addr_b, b);
            chk("stall_addr_c", addr_c, c);
        end
        tile_ready = 1'b1;
        tick;
        tile_ready = 1'b0;
        chk("wait_valid", tile_valid, 0);
        if (poke) begin
            m = 4'd4; n = 4'd4; k = 4'd4; b1 = 10'h3f0; b2 = 10'h3f4; bo = 10'h3f8;
            start = 1'b1;
        end
        tick;
        start = 1'b0;
        tick;
        tile_done = 1'b1;
        tick;
        tile_done = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", tile_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_cal", err_cal, 0);
        chk("rst_addr_a", addr_a, 0);

        // single 4x4x4 tile
        launch(4'd4, 4'd4, 4'd4, 10'd0, 10'd16, 10'd32, 1'b0);
        tick;
        chk("t1_valid_c3", tile_valid, 1);
        chk("t1_stride_a", stride_a, 4);
        chk("t1_stride_bc", stride_bc, 4);
        do_tile(10'd0, 10'd16, 10'd32, 1'b1, 1'b1, 0, 1'b0);
        tick;
        chk("t1_done", done, 1);
        chk("t1_error", error, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("t1_done_pulse", done, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_start_in_done_ignored", err_cal, 0);
        tick;
        chk("t1_still_idle", busy, 0);

        // 8x8x8: stall on tile 2, start poke during tile 3 WAIT
        hs = 0;
        launch(4'd8, 4'd8, 4'd8, 10'd0, 10'd64, 10'd128, 1'b0);
        tick;
        chk("t2_valid_c3", tile_valid, 1);
        do_tile(10'd0,  10'd64,  10'd128, 1'b1, 1'b0, 0, 1'b0);
        do_tile(10'd4,  10'd96,  10'd128, 1'b0, 1'b1, 5, 1'b0);
        do_tile(10'd0,  10'd68,  10'd132, 1'b1, 1'b0, 0, 1'b1);
        chk("t5_stride_a", stride_a, 8);
        chk("t5_stride_bc", stride_bc, 8);
        do_tile(10'd4,  10'd100, 10'd132, 1'b0, 1'b1, 0, 1'b0);
        do_tile(10'd32, 10'd64,  10'd160, 1'b1, 1'b0, 0, 1'b0);
        do_tile(10'd36, 10'd96,  10'd160, 1'b0, 1'b1, 0, 1'b0);
        do_tile(10'd32, 10'd68,  10'd164, 1'b1, 1'b0, 0, 1'b0);
        do_tile(10'd36, 10'd100, 10'd164, 1'b0, 1'b1, 0, 1'b0);
        tick;
        chk("t2_done", done, 1);
        chk("t2_handshakes", hs, 8);
        tick;
        chk("t2_idle", busy, 0);

        // rejected job
        launch(4'd5, 4'd4, 4'd4, 10'd0, 10'd16, 10'd32, 1'b1);
        tick;
        err_found = 1'b0;
        chk("t3_done_c3", done, 1);
        chk("t3_error_c3", error, 1);
        chk("t3_no_valid", tile_valid, 0);
        tick;
        chk("t3_idle", busy, 0);
        tick;
        tick;
        chk("t3_error_held", error, 1);

        // reset during WAIT, then a fresh job (launch checks error cleared)
        launch(4'd8, 4'd8, 4'd8, 10'd0, 10'd64, 10'd128, 1'b0);
        for (int i = 0; i < 20 && !tile_valid; i++) tick;
        chk("t6_valid", tile_valid, 1);
        tile_ready = 1'b1;
        tick;
        tile_ready = 1'b0;
        tick;
        dones_before = dones;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_valid0", tile_valid, 0);
        chk("t6_done0", done, 0);
        chk("t6_addr_b", addr_b, 0);
        chk("t6_stride_a", stride_a, 0);
        tile_done = 1'b1;
        tick;
        tile_done = 1'b0;
        tick;
        chk("t6_no_done", dones, dones_before);
        chk("t6_still_idle", busy, 0);
        launch(4'd4, 4'd4, 4'd4, 10'd100, 10'd200, 10'd300, 1'b0);
        do_tile(10'd100, 10'd200, 10'd300, 1'b1, 1'b1, 0, 1'b0);
        tick;
        chk("t6_fresh_done", done, 1);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
